// File: rtl/chess_board_fifo.sv
// Width-converting board queue: assembles WORD_W bursts into BOARD_W boards and queues DEPTH of them.
// Optional synchronous FLUSH input is compiled in with CHESS_FIFO_FLUSH_EN.
module chess_board_fifo #(
    parameter int unsigned BOARD_W = 256,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET,
`ifdef CHESS_FIFO_FLUSH_EN
    input  logic                         FLUSH,
`endif
    input  logic                         WR_CS,
    input  logic                         WR_WRITE,
    input  logic [WORD_W-1:0]            WR_DATA,
    output logic                         WR_WAITREQUEST,
    output logic                         BOARD_VALID,
    output logic [BOARD_W-1:0]           BOARD_DATA,
    input  logic                         BOARD_READ,
    output logic [$clog2(DEPTH+1)-1:0]   LEVEL
);

    localparam int unsigned N     = BOARD_W / WORD_W;
    localparam int unsigned CNT_W = $clog2(N);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned ASM_W = BOARD_W - WORD_W;

    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic [ASM_W-1:0]   asm_q, asm_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   count_q, count_d;
    logic [BOARD_W-1:0] mem [DEPTH];

    logic flush;
    logic last_word;
    logic full;
    logic empty;
    logic accept;
    logic push;
    logic pop;
    logic [BOARD_W-1:0] board_in;

`ifdef CHESS_FIFO_FLUSH_EN
    assign flush = FLUSH;
`else
    assign flush = 1'b0;
`endif

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Stall only the closing word of a burst, and only from registered state.
    assign last_word      = (wcnt_q == CNT_W'(N - 1));
    assign full           = (count_q == LVL_W'(DEPTH));
    assign empty          = (count_q == '0);
    assign WR_WAITREQUEST = last_word & full;

    assign accept   = WR_CS & WR_WRITE & ~WR_WAITREQUEST & ~flush;
    assign push     = accept & last_word;
    assign pop      = BOARD_READ & ~empty & ~flush;
    assign board_in = {WR_DATA, asm_q};

    assign BOARD_VALID = ~empty;
    assign BOARD_DATA  = mem[rd_ptr_q];
    assign LEVEL       = count_q;

    // Next-state for word assembly, pointers and occupancy.
    always_comb begin
        wcnt_d   = wcnt_q;
        asm_d    = asm_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (accept) begin
            for (int unsigned k = 0; k < N - 1; k++) begin
                if (wcnt_q == CNT_W'(k)) begin
                    asm_d[k*WORD_W +: WORD_W] = WR_DATA;
                end
            end
            wcnt_d = last_word ? '0 : wcnt_q + CNT_W'(1);
        end

        if (push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            wcnt_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            wcnt_q   <= '0;
            asm_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wcnt_q   <= wcnt_d;
            asm_q    <= asm_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Board storage; flush leaves contents in place since BOARD_VALID masks them.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr_q] <= board_in;
        end
    end

endmodule

// File: tb/tb_chess_board_fifo.sv
// Directed bench for chess_board_fifo (BOARD_W=256, WORD_W=32, DEPTH=4).
// The flush scenario is included when CHESS_FIFO_FLUSH_EN is defined.
module tb_chess_board_fifo;

    logic         CLOCK_50 = 1'b0;
    logic         RESET;
    logic         WR_CS;
    logic         WR_WRITE;
    logic [31:0]  WR_DATA;
    logic         WR_WAITREQUEST;
    logic         BOARD_VALID;
    logic [255:0] BOARD_DATA;
    logic         BOARD_READ;
    logic [2:0]   LEVEL;
`ifdef CHESS_FIFO_FLUSH_EN
    logic         FLUSH;
`endif

    int vectors     = 0;
    int miscompares = 0;

    chess_board_fifo #(.BOARD_W(256), .WORD_W(32), .DEPTH(4)) dut (
        .CLOCK_50       (CLOCK_50),
        .RESET          (RESET),
`ifdef CHESS_FIFO_FLUSH_EN
        .FLUSH          (FLUSH),
`endif
        .WR_CS          (WR_CS),
        .WR_WRITE       (WR_WRITE),
        .WR_DATA        (WR_DATA),
        .WR_WAITREQUEST (WR_WAITREQUEST),
        .BOARD_VALID    (BOARD_VALID),
        .BOARD_DATA     (BOARD_DATA),
        .BOARD_READ     (BOARD_READ),
        .LEVEL          (LEVEL)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] word_of(input int b, input int k);
        return 32'(b * 256 + k);
    endfunction

    function automatic logic [255:0] board_of(input int b);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = word_of(b, k);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one word and hold it until accepted (bounded).
    task automatic write_word(input logic [31:0] d);
        WR_CS    = 1'b1;
        WR_WRITE = 1'b1;
        WR_DATA  = d;
        for (int i = 0; i < 100; i++) begin
            if (!WR_WAITREQUEST) break;
            @(posedge CLOCK_50); #1;
        end
        chk("wr_stall_timeout", 256'(WR_WAITREQUEST), 256'(0));
        @(posedge CLOCK_50); #1;
        WR_CS    = 1'b0;
        WR_WRITE = 1'b0;
    endtask

    task automatic write_board(input int b);
        for (int k = 0; k < 8; k++) write_word(word_of(b, k));
    endtask

    task automatic pop_chk(input int b);
        chk("pop_valid", 256'(BOARD_VALID), 256'(1));
        chk("pop_data", BOARD_DATA, board_of(b));
        BOARD_READ = 1'b1;
        @(posedge CLOCK_50); #1;
        BOARD_READ = 1'b0;
    endtask

    initial begin
        RESET      = 1'b1;
        WR_CS      = 1'b0;
        WR_WRITE   = 1'b0;
        WR_DATA    = '0;
        BOARD_READ = 1'b0;
`ifdef CHESS_FIFO_FLUSH_EN
        FLUSH      = 1'b0;
`endif
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst_waitreq", 256'(WR_WAITREQUEST), 256'(0));
        chk("rst_valid",   256'(BOARD_VALID),    256'(0));
        chk("rst_level",   256'(LEVEL),          256'(0));
        chk("rst_data",    BOARD_DATA,           256'(0));
        RESET = 1'b0;

        // Reset mid-burst after three words.
        for (int k = 0; k < 3; k++) write_word(word_of(9, k));
        RESET = 1'b1;
        #2;
        chk("midrst_level", 256'(LEVEL),       256'(0));
        chk("midrst_valid", 256'(BOARD_VALID), 256'(0));
        @(posedge CLOCK_50); #1;
        RESET = 1'b0;

        // First burst: words 0..7 -> board {7,...,1,0}.
        for (int k = 0; k < 8; k++) begin
            write_word(word_of(0, k));
            if (k == 6) chk("b0_not_early", 256'(BOARD_VALID), 256'(0));
        end
        chk("b0_valid", 256'(BOARD_VALID), 256'(1));
        chk("b0_level", 256'(LEVEL),       256'(1));
        chk("b0_data",  BOARD_DATA, {32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1, 32'h0});
        pop_chk(0);
        chk("b0_popped_level", 256'(LEVEL),       256'(0));
        chk("b0_popped_valid", 256'(BOARD_VALID), 256'(0));

        // Fill to DEPTH, then stall the fifth board's last word.
        for (int b = 1; b <= 4; b++) write_board(b);
        chk("full_level", 256'(LEVEL), 256'(4));
        chk("full_head",  BOARD_DATA,  board_of(1));
        for (int k = 0; k < 7; k++) write_word(word_of(5, k));
        WR_CS    = 1'b1;
        WR_WRITE = 1'b1;
        WR_DATA  = word_of(5, 7);
        chk("stall_wr_a", 256'(WR_WAITREQUEST), 256'(1));
        @(posedge CLOCK_50); #1;
        chk("stall_wr_b",  256'(WR_WAITREQUEST), 256'(1));
        chk("stall_level", 256'(LEVEL),          256'(4));
        BOARD_READ = 1'b1;
        @(posedge CLOCK_50); #1;
        BOARD_READ = 1'b0;
        chk("unstall_level", 256'(LEVEL),          256'(3));
        chk("unstall_wr",    256'(WR_WAITREQUEST), 256'(0));
        chk("unstall_head",  BOARD_DATA,           board_of(2));
        @(posedge CLOCK_50); #1;
        WR_CS    = 1'b0;
        WR_WRITE = 1'b0;
        chk("refill_level", 256'(LEVEL), 256'(4));
        chk("refill_head",  BOARD_DATA,  board_of(2));
        for (int b = 2; b <= 5; b++) pop_chk(b);
        chk("drain_valid", 256'(BOARD_VALID), 256'(0));

        // Reads on an empty FIFO must be ignored.
        BOARD_READ = 1'b1;
        repeat (5) begin
            @(posedge CLOCK_50); #1;
            chk("empty_rd_level", 256'(LEVEL), 256'(0));
        end
        BOARD_READ = 1'b0;
        write_board(6);
        chk("after_empty_level", 256'(LEVEL), 256'(1));
        pop_chk(6);

        // Push and pop in the same cycle with LEVEL=2.
        write_board(7);
        write_board(8);
        chk("sim_pre_level", 256'(LEVEL), 256'(2));
        for (int k = 0; k < 7; k++) write_word(word_of(9, k));
        WR_CS      = 1'b1;
        WR_WRITE   = 1'b1;
        WR_DATA    = word_of(9, 7);
        BOARD_READ = 1'b1;
        @(posedge CLOCK_50); #1;
        WR_CS      = 1'b0;
        WR_WRITE   = 1'b0;
        BOARD_READ = 1'b0;
        chk("sim_level", 256'(LEVEL), 256'(2));
        chk("sim_head",  BOARD_DATA,  board_of(8));
        pop_chk(8);
        pop_chk(9);

        // Stream 20 boards with pops, wrapping the pointers several times.
        for (int b = 10; b < 30; b++) begin
            write_board(b);
            if (b >= 12) pop_chk(b - 2);
        end
        pop_chk(28);
        pop_chk(29);
        chk("stream_empty", 256'(BOARD_VALID), 256'(0));

`ifdef CHESS_FIFO_FLUSH_EN
        for (int b = 30; b < 33; b++) write_board(b);
        for (int k = 0; k < 5; k++) write_word(word_of(33, k));
        chk("pre_flush_level", 256'(LEVEL), 256'(3));
        FLUSH = 1'b1;
        @(posedge CLOCK_50); #1;
        FLUSH = 1'b0;
        chk("flush_level",   256'(LEVEL),          256'(0));
        chk("flush_valid",   256'(BOARD_VALID),    256'(0));
        chk("flush_waitreq", 256'(WR_WAITREQUEST), 256'(0));
        write_board(34);
        chk("post_flush_level", 256'(LEVEL), 256'(1));
        pop_chk(34);
        chk("post_flush_empty", 256'(BOARD_VALID), 256'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/chess_board_fifo.md
# chess_board_fifo

Board-transfer buffer between the HPS-side 32-bit register bus and the chess engine's 256-bit board port. HPS software writes a board position as a burst of narrow words. The block assembles each burst into one full-width board and queues completed boards in a DEPTH-entry FIFO. The engine then pops whole boards through a valid/read handshake. It replaces the single fixed-width, unbuffered board slot with a parametrised, queued, width-converting path.

## Interface
- BOARD_W, 256, board width in bits; must be an integer multiple of WORD_W
- WORD_W, 32, HPS write-word width; N = BOARD_W/WORD_W ≥ 2 words per board
- DEPTH, 4, FIFO entries in boards; ≥ 1, any integer
- CLOCK_50  in  1  sole clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- WR_CS  in  1  HPS chip select
- WR_WRITE  in  1  HPS write strobe
- WR_DATA  in  WORD_W  HPS write word
- WR_WAITREQUEST  out  1  word not accepted this cycle; HPS holds WR_CS, WR_WRITE and WR_DATA stable
- BOARD_VALID  out  1  head board present
- BOARD_DATA  out  BOARD_W  head board
- BOARD_READ  in  1  engine pops the head board
- LEVEL  out  $clog2(DEPTH+1)  boards queued
- FLUSH  in  1  present only with CHESS_FIFO_FLUSH_EN

## Operation
- Accept condition: WR_CS & WR_WRITE & ~WR_WAITREQUEST.
- Word counter wcnt runs 0..N-1.
  - Accepted word k goes to the assembly register at bits [k*WORD_W +: WORD_W]; word 0 is the LSBs.
  - wcnt increments on each accept.
  - On accepting word N-1, the assembled board (including that word) is pushed to the FIFO and wcnt returns to 0.
- WR_WAITREQUEST = (wcnt == N-1) & (LEVEL == DEPTH).
  - Combinational; depends only on registered state.
  - Words 0..N-2 are never stalled.
- FIFO behaviour:
  - Write pointer and read pointer each wrap from DEPTH-1 to 0.
  - Count range is 0..DEPTH; LEVEL = count.
  - BOARD_VALID = (count ≠ 0).
  - BOARD_DATA = storage[rd_ptr], read directly from storage with no output register.
- Pop: on BOARD_READ & BOARD_VALID. BOARD_READ while empty is ignored; no state changes.
- Simultaneous push and pop:
  - Not full: both happen; count is unchanged and both pointers advance.
  - Full: the push is stalled by WR_WAITREQUEST even though a pop occurs in the same cycle. There is no combinational path from BOARD_READ to WR_WAITREQUEST.
- With DEPTH = 1, push and pop together are only possible when empty? No: when count = 1, the push stalls, so the empty-pop case does not arise. The pop proceeds normally.
- A partial board (wcnt ≠ 0) stays pending indefinitely. There is no timeout.
- Reset value of every output (RESET asserted):
  - wcnt, pointers, count and all storage, including the assembly register, clear to 0.
  - WR_WAITREQUEST = 0, BOARD_VALID = 0, LEVEL = 0, BOARD_DATA = 0.
- RESET mid-burst discards the partial board and all queued boards.

## Timing
- Push latency: last word accepted at edge t → BOARD_VALID = 1 and BOARD_DATA valid immediately after edge t, provided the FIFO was empty. LEVEL updates at the same edge.
- Pop: BOARD_READ sampled at edge t → the next board, or BOARD_VALID = 0, appears after edge t.
- Full throughput:
  - One word per cycle.
  - One board per N cycles into the FIFO.
  - One board per cycle out of the FIFO.
- WR_WAITREQUEST deasserts the cycle after the first pop from a full FIFO. The stalled word N-1 is accepted at that edge.

## Configuration
- CHESS_FIFO_FLUSH_EN defined:
  - The FLUSH input exists.
  - FLUSH high at an edge sets wcnt and count to 0 and resets both pointers.
  - Any same-cycle accept or pop is discarded.
  - Storage contents are not cleared; BOARD_VALID = 0 masks them.
  - WR_WAITREQUEST is 0 the following cycle.
- CHESS_FIFO_FLUSH_EN undefined: the FLUSH port and its logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset → WR_WAITREQUEST=0, BOARD_VALID=0, LEVEL=0, BOARD_DATA=0; RESET asserted mid-burst after 3 words → wcnt=0, LEVEL=0.
- Write words 0x00000000..0x00000007 back-to-back → after the 8th accept, BOARD_VALID=1, LEVEL=1, BOARD_DATA = {32'h7,...,32'h1,32'h0}.
- Write 5 boards with no pops (DEPTH=4) → boards 1–4 accepted, LEVEL=4, 5th board's word 7 held with WR_WAITREQUEST=1; one pop → word 7 accepted the next cycle, LEVEL=4, board 2 at head.
- Pop while writing word 7 with LEVEL=2 → LEVEL stays 2; pop order 1,2,3 matches write order across pointer wrap (20 boards streamed).
- BOARD_READ=1 with LEVEL=0 for 5 cycles → LEVEL stays 0, no pointer movement; the following board reads back correctly.
- CHESS_FIFO_FLUSH_EN: LEVEL=3 and wcnt=5, pulse FLUSH → LEVEL=0, BOARD_VALID=0; a new 8-word burst yields exactly that board.
